integrator: RTL and testbench
=============================

// Module: integrator
// PURPOSE
//  3-axis inertial integrator: each update runs semi-implicit Euler, v += a*dt then p += v*dt, per axis.
//  Sits behind the accelerometer front-end; feeds velocity/position to the navigation logic.
//  Multiplies run one at a time on a single shared sequential signed multiplier, flagged by bussy.
// PARAMETERS
//  WIDTH  16  data width of a*, dt, v*, p* (two's complement)
//  FRAC    8  fractional bits; all operands and results are Q(WIDTH-FRAC).FRAC
// PORTS
//  clk     in   1   single clock, rising edge
//  rst     in   1   reset: asynchronous, active-low
//  enable  in   1   level request; sampled only in IDLE
//  acx     in   16  X acceleration, signed Q8.8
//  acy     in   16  Y acceleration, signed Q8.8
//  acz     in   16  Z acceleration, signed Q8.8
//  dt      in   16  time step, signed Q8.8
//  vx      out  16  X velocity, signed Q8.8, registered
//  vy      out  16  Y velocity, signed Q8.8, registered
//  vz      out  16  Z velocity, signed Q8.8, registered
//  px      out  16  X position, signed Q8.8, registered
//  py      out  16  Y position, signed Q8.8, registered
//  pz      out  16  Z position, signed Q8.8, registered
//  bussy   out  1   high while an update is in progress
// BEHAVIOUR
//  - rst low: all six outputs, internal v/p state and bussy cleared to 0; state forced to IDLE.
//  - rst low mid-update aborts the update; no partial result is ever visible.
//  - IDLE + enable=1 at an edge: latch acx/acy/acz/dt; go busy; bussy=1 from that edge.
//  - Operation order: vx, px, vy, py, vz, pz.
//    - v op: v_new = sat(v + mul(a,dt)).
//    - p op: p_new = sat(p + mul(v_new,dt)).
//  - Each op: MUL state, 16 cycles (one multiplier bit per cycle), then ACC state, 1 cycle.
//    - 17 cycles per op; 102 cycles per update.
//  - On the ACC edge of op 6: all six outputs update together, bussy->0, state->IDLE.
//  - Throughput:
//    - enable held high restarts on the next edge in IDLE; period 103 cycles.
//    - bussy stays low for exactly 1 cycle between updates.
//  - Input changes while bussy=1 are ignored (latched copies used).
//  - Dropping enable while bussy=1 does not abort; the update completes.
//  - mul(x,y): full signed 32-bit product, arithmetic shift right by FRAC (floor), then saturate.
//  - sat(): clamp to 0x7FFF / 0x8000 on overflow; no wrap-around, ever.
//  - Outputs hold their value between updates; v/p accumulate across updates until reset.
//  - FSM states: IDLE, MUL, ACC. Op index 0..5 and bit counter 0..15 are side registers.
// STRUCTURE
//  - Package integrator_pkg:
//    - state enum {IDLE,MUL,ACC}
//    - WIDTH, FRAC defaults
//    - SAT_MAX=16'h7FFF, SAT_MIN=16'h8000
//  - Sub-module seq_mult:
//    - signed 16x16 shift-add (Booth optional)
//    - start/done handshake, done 16 cycles after start, 32-bit product
//  - Top: FSM, operand mux, truncate/saturate adder, v/p registers.
// TESTING
//  - Reset: rst=0 any time -> all outputs 0, bussy 0; rst=0 at cycle 50 of an update -> outputs stay 0.
//  - Basic update, period:
//    - a=(00AA,007A,003A), dt=000A, enable=1 -> after 102 cycles v=(0006,0004,0002), p=(0000,0000,0000).
//    - next update v=(000C,0008,0004).
//  - Unit dt: acx=00AA, dt=0100 -> update1 vx=00AA, px=00AA; update2 vx=0154, px=01FE.
//  - Negative: acx=FF00, dt=0100 -> vx=FF00, px=FF00; update2 vx=FE00, px=FD00.
//  - Saturation: acx=7FFF, dt=7FFF -> vx=7FFF after update1; stays 7FFF, never wraps negative.
//  - Handshake:
//    - bussy high exactly 102 cycles.
//    - enable pulsed 1 cycle -> exactly one update.
//    - input changes while busy do not alter results.

Source files
------------

// File: rtl/integrator_pkg.sv
// Shared types, fixed-point parameters and saturation helpers for the 3-axis integrator.
package integrator_pkg;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int PW    = 2 * WIDTH;

  localparam logic [WIDTH-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [WIDTH-1:0] SAT_MIN = 16'h8000;

  localparam logic signed [PW-1:0] PROD_MAX = {{(PW-WIDTH){1'b0}}, SAT_MAX};
  localparam logic signed [PW-1:0] PROD_MIN = {{(PW-WIDTH){1'b1}}, SAT_MIN};

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  // Full product to Q8.8: arithmetic shift (floor), then clamp.
  function automatic logic [WIDTH-1:0] sat_prod(input logic signed [PW-1:0] prod);
    logic signed [PW-1:0] sh;
    sh = prod >>> FRAC;
    if (sh > PROD_MAX)      return SAT_MAX;
    else if (sh < PROD_MIN) return SAT_MIN;
    else                    return sh[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? SAT_MIN : SAT_MAX;
    else                        return s[WIDTH-1:0];
  endfunction
endpackage

// File: rtl/integrator_seq_mult.sv
// Signed 16x16 shift-add multiplier, one multiplier bit per cycle.
// i_start loads operands; o_done is high during the 16th bit cycle, o_product is final after it.
module seq_mult
  import integrator_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic signed [PW-1:0] o_product
);
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_prod;
  logic [3:0]       r_cnt;
  logic             r_busy;
  logic [PW-1:0]    w_term;

  // The sign bit of the multiplier carries negative weight (two's complement).
  assign w_term    = (r_cnt == 4'd15) ? (PW'(0) - r_mcand) : r_mcand;
  assign o_done    = r_busy && (r_cnt == 4'd15);
  assign o_product = r_prod;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{(PW-WIDTH){i_a[WIDTH-1]}}, i_a};
      r_mplier <= i_b;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) r_prod <= r_prod + w_term;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 4'd1;
      if (r_cnt == 4'd15) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/integrator.sv
// 3-axis semi-implicit Euler integrator: v += a*dt then p += v*dt per axis,
// all six multiplies sharing one sequential multiplier; outputs commit together.
module integrator
  import integrator_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] acx,
  input  logic [WIDTH-1:0] acy,
  input  logic [WIDTH-1:0] acz,
  input  logic [WIDTH-1:0] dt,
  output logic [WIDTH-1:0] vx,
  output logic [WIDTH-1:0] vy,
  output logic [WIDTH-1:0] vz,
  output logic [WIDTH-1:0] px,
  output logic [WIDTH-1:0] py,
  output logic [WIDTH-1:0] pz,
  output logic             bussy
);
  state_t           r_state, w_next;
  logic [2:0]       r_op, w_nop;
  logic [1:0]       w_axis;
  logic [WIDTH-1:0] r_a [0:2];
  logic [WIDTH-1:0] r_v [0:2];
  logic [WIDTH-1:0] r_p [0:2];
  logic [WIDTH-1:0] r_dt;
  logic [WIDTH-1:0] w_old, w_res, w_op_a, w_op_b;
  logic             w_start, w_mul_done;
  logic signed [PW-1:0] w_product;

  assign w_axis = r_op[2:1];
  assign w_nop  = r_op + 3'd1;
  assign w_res  = sat_add(w_old, sat_prod(w_product));

  seq_mult u_mult (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_start   (w_start),
    .i_a       (w_op_a),
    .i_b       (w_op_b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_comb begin
    w_old = '0;
    case (w_axis)
      2'd0:    w_old = r_op[0] ? r_p[0] : r_v[0];
      2'd1:    w_old = r_op[0] ? r_p[1] : r_v[1];
      default: w_old = r_op[0] ? r_p[2] : r_v[2];
    endcase
  end

  // Operands for the op being started: raw inputs on launch, else the latched
  // copies; a position op multiplies the velocity just produced in this ACC cycle.
  always_comb begin
    w_op_a = r_a[0];
    w_op_b = r_dt;
    if (r_state == IDLE) begin
      w_op_a = acx;
      w_op_b = dt;
    end else if (w_nop[0]) begin
      w_op_a = w_res;
    end else begin
      case (w_nop[2:1])
        2'd0:    w_op_a = r_a[0];
        2'd1:    w_op_a = r_a[1];
        default: w_op_a = r_a[2];
      endcase
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE: if (enable) begin
        w_next  = MUL;
        w_start = 1'b1;
      end
      MUL:  if (w_mul_done) w_next = ACC;
      ACC:  if (r_op == 3'd5) w_next = IDLE;
            else begin
              w_next  = MUL;
              w_start = 1'b1;
            end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_dt    <= '0;
      for (int i = 0; i < 3; i++) begin
        r_a[i] <= '0;
        r_v[i] <= '0;
        r_p[i] <= '0;
      end
      vx <= '0; vy <= '0; vz <= '0;
      px <= '0; py <= '0; pz <= '0;
      bussy <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && enable) begin
        r_a[0] <= acx;
        r_a[1] <= acy;
        r_a[2] <= acz;
        r_dt   <= dt;
        r_op   <= '0;
        bussy  <= 1'b1;
      end
      if (r_state == ACC) begin
        if (r_op[0]) r_p[w_axis] <= w_res;
        else         r_v[w_axis] <= w_res;
        r_op <= w_nop;
        if (r_op == 3'd5) begin
          vx <= r_v[0]; vy <= r_v[1]; vz <= r_v[2];
          px <= r_p[0]; py <= r_p[1]; pz <= w_res;
          bussy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_integrator.sv
// Directed bench for the integrator: table of update vectors plus reset/throughput sequences.
module tb_integrator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] acx = '0, acy = '0, acz = '0, dt = '0;
  logic [15:0] vx, vy, vz, px, py, pz;
  logic        bussy;

  int total = 0;
  int bad   = 0;
  logic [15:0] cur_exp [6];

  typedef struct {
    logic        rst_first;
    logic [15:0] ax, ay, az, dtv;
    logic [15:0] evx, evy, evz, epx, epy, epz;
  } vec_t;
  vec_t vecs [12];

  integrator dut (
    .clk(clk), .rst(rst), .enable(enable),
    .acx(acx), .acy(acy), .acz(acz), .dt(dt),
    .vx(vx), .vy(vy), .vz(vz), .px(px), .py(py), .pz(pz),
    .bussy(bussy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e [6]);
    chk({tag, "_vx"}, vx, e[0]);
    chk({tag, "_vy"}, vy, e[1]);
    chk({tag, "_vz"}, vz, e[2]);
    chk({tag, "_px"}, px, e[3]);
    chk({tag, "_py"}, py, e[4]);
    chk({tag, "_pz"}, pz, e[5]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) cur_exp[i] = '0;
    chk_all("reset", cur_exp);
    chk("reset_bussy", {15'd0, bussy}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One enable pulse; inputs are scrambled while busy to prove they are latched.
  task automatic run_update(input logic [15:0] ax, ay, az, dtv, output int n);
    @(negedge clk);
    acx = ax; acy = ay; acz = az; dt = dtv;
    enable = 1'b1;
    @(posedge clk); #1;
    chk("bussy_rise", {15'd0, bussy}, 16'd1);
    @(negedge clk);
    enable = 1'b0;
    acx = 16'($urandom_range(0, 65535));
    acy = 16'($urandom_range(0, 65535));
    acz = 16'($urandom_range(0, 65535));
    dt  = 16'($urandom_range(0, 65535));
    n = 1;
    while (n < 300) begin
      @(posedge clk); #1;
      if (!bussy) break;
      n++;
      if (n == 50) begin
        chk("mid_vx_hold", vx, cur_exp[0]);
        chk("mid_pz_hold", pz, cur_exp[5]);
      end
    end
  endtask

  initial begin
    int n;
    int t;
    logic [15:0] e [6];

    vecs[0]  = '{1'b1, 16'h00AA, 16'h007A, 16'h003A, 16'h000A, 16'h0006, 16'h0004, 16'h0002, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 16'h00AA, 16'h007A, 16'h003A, 16'h000A, 16'h000C, 16'h0008, 16'h0004, 16'h0000, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 16'h00AA, 16'h0000, 16'h0000, 16'h0100, 16'h00AA, 16'h0000, 16'h0000, 16'h00AA, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 16'h00AA, 16'h0000, 16'h0000, 16'h0100, 16'h0154, 16'h0000, 16'h0000, 16'h01FE, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 16'hFF00, 16'h0000, 16'h0000, 16'h0100, 16'hFF00, 16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 16'hFF00, 16'h0000, 16'h0000, 16'h0100, 16'hFE00, 16'h0000, 16'h0000, 16'hFD00, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b1, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 16'hFFFF, 16'h8000, 16'h0100, 16'h0100, 16'hFFFF, 16'h8000, 16'h0100, 16'hFFFF, 16'h8000, 16'h0100};
    vecs[9]  = '{1'b0, 16'hFFFF, 16'h8000, 16'h0100, 16'h0100, 16'hFFFE, 16'h8000, 16'h0200, 16'hFFFD, 16'h8000, 16'h0300};
    vecs[10] = '{1'b1, 16'h0100, 16'hFE00, 16'h0080, 16'h0080, 16'h0080, 16'hFF00, 16'h0040, 16'h0040, 16'hFF80, 16'h0020};
    vecs[11] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'h000A, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};

    for (int i = 0; i < 6; i++) cur_exp[i] = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst_first) do_reset();
      run_update(vecs[i].ax, vecs[i].ay, vecs[i].az, vecs[i].dtv, n);
      chk($sformatf("v%0d_busy_cycles", i), 16'(n), 16'd102);
      e = '{vecs[i].evx, vecs[i].evy, vecs[i].evz, vecs[i].epx, vecs[i].epy, vecs[i].epz};
      chk_all($sformatf("v%0d", i), e);
      cur_exp = e;
    end

    // A single enable pulse gives exactly one update.
    repeat (5) @(posedge clk);
    #1;
    chk("pulse_single_update", {15'd0, bussy}, 16'd0);

    // Enable held high: fall after 102, restart after exactly one idle cycle.
    do_reset();
    @(negedge clk);
    acx = 16'h00AA; acy = '0; acz = '0; dt = 16'h0100;
    enable = 1'b1;
    @(posedge clk); #1;
    t = 0;
    while (bussy && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("held_fall_at", 16'(t), 16'd102);
    while (!bussy && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("held_period", 16'(t), 16'd103);
    @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (bussy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_second_done", {15'd0, bussy}, 16'd0);
    chk("held_vx", vx, 16'h0154);
    chk("held_px", px, 16'h01FE);
    repeat (5) @(posedge clk);
    #1;
    chk("held_no_third", {15'd0, bussy}, 16'd0);

    // Reset asserted mid-update: nothing partial leaks, next update starts clean.
    do_reset();
    @(negedge clk);
    acx = 16'h00AA; acy = 16'h0055; acz = 16'h0033; dt = 16'h0100;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_bussy", {15'd0, bussy}, 16'd0);
    chk_all("abort", cur_exp);
    @(negedge clk);
    rst = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    chk("abort_after_bussy", {15'd0, bussy}, 16'd0);
    chk_all("abort_after", cur_exp);
    run_update(16'h00AA, 16'h0000, 16'h0000, 16'h0100, n);
    chk("restart_busy_cycles", 16'(n), 16'd102);
    e = '{16'h00AA, 16'h0000, 16'h0000, 16'h00AA, 16'h0000, 16'h0000};
    chk_all("restart", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
